// File: rtl/pong_graph_anim.sv
// Pixel generator for the pong screen: left wall, button-driven right paddle and
// a bouncing ball, rendered one pixel per clk behind the 640x480 sync generator.
// Animation state advances once per frame on refr_tick, during vertical blanking.
// Optional feature: define ROUND_BALL_EN to draw the ball through an 8x8 round mask.
module pong_graph_anim #(
  parameter int unsigned BALL_V    = 2,
  parameter int unsigned PAD_V     = 4,
  parameter int unsigned PAD_H     = 72,
  parameter int unsigned BALL_SIZE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        p_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [1:0]  btn,
  output logic [11:0] rgb,
  output logic        hit,
  output logic        miss
);

  // Screen geometry
  localparam logic [9:0] MaxX     = 10'd639;
  localparam logic [9:0] MaxY     = 10'd479;
  localparam logic [9:0] WallL    = 10'd32;
  localparam logic [9:0] WallR    = 10'd35;
  localparam logic [9:0] BarL     = 10'd600;
  localparam logic [9:0] BarR     = 10'd603;
  localparam logic [9:0] BallXRst = 10'd316;
  localparam logic [9:0] BallYRst = 10'd236;
  localparam logic [9:0] BarYRst  = 10'd204;
  localparam logic [9:0] BallV    = 10'(BALL_V);
  localparam logic [9:0] PadV     = 10'(PAD_V);
  localparam logic [9:0] PadH     = 10'(PAD_H);
`ifdef ROUND_BALL_EN
  // The mask ROM is 8x8, so the ball size is pinned to match it.
  localparam logic [9:0] BSize    = 10'd8;
`else
  localparam logic [9:0] BSize    = 10'(BALL_SIZE);
`endif
  localparam logic [9:0] BarYLim  = MaxY - PadV;
  localparam logic [9:0] BallYLim = MaxY - BallV;

  localparam logic [11:0] ColWall = 12'h00F;
  localparam logic [11:0] ColBar  = 12'h0F0;
  localparam logic [11:0] ColBall = 12'hF00;
  localparam logic [11:0] ColBg   = 12'h000;

  // Animation state; velocities kept as a direction bit, magnitude is BallV
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic [9:0] bar_y_q, bar_y_d;
  logic       hit_d, miss_d;

  logic       refr_tick;
  logic [9:0] ball_r, ball_b, bar_b;
  logic       wall_on, bar_on, sq_on, ball_on;
  logic [11:0] color;

  assign refr_tick = p_tick & (pixel_x == 10'd0) & (pixel_y == 10'd481);
  assign ball_r    = ball_x_q + BSize - 10'd1;
  assign ball_b    = ball_y_q + BSize - 10'd1;
  assign bar_b     = bar_y_q + PadH - 10'd1;

  // Per-frame paddle and ball update; collisions use the bounding box
  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    bar_y_d  = bar_y_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (refr_tick) begin
      if (btn == 2'b10 && bar_b < BarYLim) begin
        bar_y_d = bar_y_q + PadV;
      end else if (btn == 2'b01 && bar_y_q > PadV) begin
        bar_y_d = bar_y_q - PadV;
      end

      if (ball_r >= MaxX) begin
        // Recentre without stepping; vertical direction is kept
        ball_x_d = BallXRst;
        ball_y_d = BallYRst;
        dx_neg_d = 1'b1;
        miss_d   = 1'b1;
      end else begin
        if (ball_r >= BarL && ball_r <= BarR && ball_b >= bar_y_q && ball_y_q <= bar_b) begin
          dx_neg_d = 1'b1;
          hit_d    = 1'b1;
        end else if (ball_x_q <= WallR) begin
          dx_neg_d = 1'b0;
        end
        if (ball_y_q <= BallV) begin
          dy_neg_d = 1'b0;
        end else if (ball_b >= BallYLim) begin
          dy_neg_d = 1'b1;
        end
        // New direction applies on this same step
        ball_x_d = dx_neg_d ? ball_x_q - BallV : ball_x_q + BallV;
        ball_y_d = dy_neg_d ? ball_y_q - BallV : ball_y_q + BallV;
      end
    end
  end

  // Animation state and event pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x_q <= BallXRst;
      ball_y_q <= BallYRst;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      bar_y_q  <= BarYRst;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      bar_y_q  <= bar_y_d;
      hit      <= hit_d;
      miss     <= miss_d;
    end
  end

  assign wall_on = (pixel_x >= WallL) && (pixel_x <= WallR);
  assign bar_on  = (pixel_x >= BarL) && (pixel_x <= BarR) &&
                   (pixel_y >= bar_y_q) && (pixel_y <= bar_b);
  assign sq_on   = (pixel_x >= ball_x_q) && (pixel_x <= ball_r) &&
                   (pixel_y >= ball_y_q) && (pixel_y <= ball_b);

`ifdef ROUND_BALL_EN
  logic [2:0] rom_row, rom_col;
  logic [7:0] rom_data;

  // Low 3 bits of the offset are enough since the ball is 8 pixels wide
  assign rom_row = pixel_y[2:0] - ball_y_q[2:0];
  assign rom_col = pixel_x[2:0] - ball_x_q[2:0];

  // Round ball mask ROM, MSB is the leftmost pixel
  always_comb begin
    rom_data = 8'h00;
    unique case (rom_row)
      3'd0:    rom_data = 8'h3C;
      3'd1:    rom_data = 8'h7E;
      3'd6:    rom_data = 8'h7E;
      3'd7:    rom_data = 8'h3C;
      default: rom_data = 8'hFF;
    endcase
  end

  assign ball_on = sq_on & rom_data[~rom_col];
`else
  assign ball_on = sq_on;
`endif

  // Colour priority: wall over paddle over ball over background
  always_comb begin
    color = ColBg;
    if (wall_on) begin
      color = ColWall;
    end else if (bar_on) begin
      color = ColBar;
    end else if (ball_on) begin
      color = ColBall;
    end
  end

  // Registered pixel colour, blanked outside the visible area
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 12'h000;
    end else begin
      rgb <= video_on ? color : 12'h000;
    end
  end

endmodule

// File: doc/pong_graph_anim.md
Name: pong_graph_anim

Overview:
Pixel-generation stage directly downstream of the 640x480 VGA sync generator. Consumes pixel_x/pixel_y/video_on/p_tick and produces the 12-bit RGB colour for each pixel. Renders a left wall, a button-driven right paddle and a bouncing ball. Animation state updates once per frame, during vertical blanking.

Parameters:
BALL_V, 2, ball speed per frame in pixels, each axis
PAD_V, 4, paddle speed per frame in pixels
PAD_H, 72, paddle height in pixels
BALL_SIZE, 8, ball edge length in pixels (fixed at 8 when ROUND_BALL_EN is defined)

Ports:
clk  in  1  system clock (50 MHz; pixel rate 25 MHz via p_tick)
reset  in  1  asynchronous, active-high
video_on  in  1  high inside the 640x480 visible area
p_tick  in  1  25 MHz pixel enable, one clk wide
pixel_x  in  10  current column, 0..799
pixel_y  in  10  current row, 0..524
btn  in  2  btn[0]=paddle up, btn[1]=paddle down; synchronous, level
rgb  out  12  {R4,G4,B4} pixel colour, registered
hit  out  1  one-clk pulse when the ball bounces off the paddle
miss  out  1  one-clk pulse when the ball passes the paddle

Behaviour:
- Reset (async, active-high) values:
  - ball_x=316, ball_y=236
  - dx=+BALL_V, dy=+BALL_V
  - bar_y=204
  - rgb=0, hit=0, miss=0
- refr_tick = p_tick & (pixel_x==0) & (pixel_y==481). Exactly one clk per frame.
- All position/velocity registers change only on refr_tick. Rendering uses stable values for the whole visible frame.
- Geometry, all bounds inclusive:
  - wall: x 32..35
  - paddle: x 600..603, y bar_y..bar_y+PAD_H-1
  - ball: x ball_x..ball_x+BALL_SIZE-1, y ball_y..ball_y+BALL_SIZE-1
- Paddle update on refr_tick:
  - btn==2'b10 and bar_y+PAD_H-1 < 479-PAD_V: bar_y += PAD_V.
  - btn==2'b01 and bar_y > PAD_V: bar_y -= PAD_V.
  - btn==2'b11, btn==2'b00, or limit reached: bar_y unchanged.
- Ball update on refr_tick. X-direction priority, highest first:
  - Miss: ball_x+BALL_SIZE-1 >= 639. Recentre to (316,236), dx=-BALL_V, dy unchanged, assert miss for that clk.
  - Paddle hit: ball_x+BALL_SIZE-1 in 600..603, ball_y+BALL_SIZE-1 >= bar_y, and ball_y <= bar_y+PAD_H-1. Set dx=-BALL_V, assert hit.
  - Wall: ball_x <= 35. Set dx=+BALL_V.
- Y direction, evaluated independently of X:
  - ball_y <= BALL_V: dy=+BALL_V.
  - ball_y+BALL_SIZE-1 >= 479-BALL_V: dy=-BALL_V.
- Position on refr_tick: ball_x += dx_new, ball_y += dy_new (new direction applies immediately). Miss cycle is the exception: position is set to the centre with no step added.
- Arithmetic: 10-bit unsigned positions; velocity held as a sign bit plus magnitude. No wrap is reachable given the bounce limits.
- Colour selection, priority wall > paddle > ball > background:
  - wall 12'h00F
  - paddle 12'h0F0
  - ball 12'hF00
  - background 12'h000
- rgb update: rgb <= video_on ? selected colour : 12'h000, registered every clk, 1 clk latency from pixel_x/pixel_y.
- hit/miss: registered, high exactly one clk, coincident with the update cycle.
- Reset mid-frame: all state returns to reset values immediately. Motion resumes at the next refr_tick after reset deasserts.

Optional Feature:
ROUND_BALL_EN
- Defined: ball pixel is drawn only where an 8x8 mask bit is set.
  - Mask rows y0..y7: 3C,7E,FF,FF,FF,FF,7E,3C.
  - Bit index is 7-(pixel_x-ball_x).
  - Corners inside the bounding box show lower-priority colour (background).
- Not defined: the whole BALL_SIZE x BALL_SIZE square is ball colour.
- Collision logic always uses the bounding box, with or without the macro.

Test Plan:
- Reset release, no buttons, one frame -> at the first refr_tick ball moves (316,236)->(318,238); bar_y stays 204; at pixel (320,240) rgb=12'hF00 one clk after.
- Hold btn=2'b10 for 70 frames -> bar_y steps +4 per frame and saturates at 404 (404+71=475 not < 475); btn=2'b11 -> no change.
- Force ball_x=592 (right edge 599), dx=+2, bar_y=204, ball_y=230, run 1 frame -> ball_x=594, right edge 601; next frame hit=1 for one clk, dx becomes -2, ball_x=592.
- Ball approaching right side with bar_y=0 -> ball passes paddle, miss=1 for one clk on the frame where right edge >=639, ball at (316,236), dx=-2.
- Ball at ball_x=34, dx=-2 -> next refr_tick dx=+2, ball_x=36; ball_y=2, dy=-2 -> dy=+2, ball_y=4.
- Pixel (33,100) with video_on=1 -> rgb=12'h00F; pixel (700,100) with video_on=0 -> rgb=12'h000. With ROUND_BALL_EN: pixel (ball_x,ball_y) -> 12'h000; pixel (ball_x+3,ball_y) -> 12'hF00.
